ecc_37_wr_enc: RTL and testbench
================================

# ecc_37_wr_enc

Write-side companion of the 37-bit SECDED checker on the FIFO ECC path. The block accepts 37-bit data words over a valid/ready stream and computes the 7 check bits. It buffers the result in a 2-entry output queue and presents a 44-bit codeword toward the FIFO storage write port. A one-shot fault-injection facility can corrupt one or two codeword bits of a single word, so the read-side checker's single-bit and double-bit paths can be exercised in-system.

## Interface
- DATA_WIDTH, 37, data bits per word (fixed; check-bit equations below are defined for 37)
- PARITY_WIDTH, 7, check bits per word
- CW_WIDTH, 44, codeword width = DATA_WIDTH + PARITY_WIDTH
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  37  input data word
- out_valid  out  1  codeword valid
- out_ready  in  1  downstream accepts codeword
- out_cw  out  44  codeword {parity[6:0], data[36:0]}, after any injected flips
- inj_arm  in  1  one-cycle pulse: arm injection for the next accepted word
- inj_double  in  1  sampled with inj_arm: 0 = single flip, 1 = double flip
- inj_pos0  in  6  sampled with inj_arm: first codeword bit to flip
- inj_pos1  in  6  sampled with inj_arm: second bit (double mode only)
- inj_armed  out  1  injection armed and pending
- inj_done  out  1  one-cycle pulse: an armed injection was applied
- word_cnt  out  16  count of accepted input words

## Operation
- Check-bit code: data bit i is assigned code c(i) = the i-th integer, counting from 0, in the ascending sequence of integers ≥3 that are not powers of two (3,5,6,7,9,10,…,43).
  - For j in 0..5: parity[j] = XOR of in_data[i] over all i where c(i) has bit j set.
  - parity[6] = XOR of in_data[i] over all i where popcount(c(i)) is even.
  - These equations must match the read-side checker exactly.
- Accept: a word is accepted when in_valid && in_ready. Its codeword is encoded combinationally and written into the queue on the same edge.
- Queue: 2 entries, in order. in_ready = (count != 2), driven from a registered count, not from out_ready. Pop when out_valid && out_ready. out_valid = (count != 0). out_cw = head entry.
- Injection arming: an inj_arm pulse sets inj_armed and captures inj_double, inj_pos0 and inj_pos1. A re-arm while already armed overwrites the captured values.
- Injection apply: the first word accepted while inj_armed = 1 is XORed with the flip mask before it enters the queue. inj_armed then clears and inj_done pulses on the following cycle.
  - Flip mask = onehot(pos0), OR onehot(pos1) in double mode.
  - Positions ≥44 contribute no flip.
  - pos0 == pos1 in double mode means a single flip at that position.
- Arm and accept in the same cycle: the accepted word uses the injection state held before that edge. The new arm takes effect for the next accepted word, so inj_armed stays 1.
- word_cnt: increments by 1 per accepted word and wraps from 0xFFFF to 0. Injection has no effect on it.
- Queue contents are never altered after enqueue. Stalls hold out_cw stable.

## Timing
- Reset values: in_ready = 1 on the first cycle after reset deassertion; out_valid = 0; out_cw = 0; inj_armed = 0; inj_done = 0; word_cnt = 0; queue empty; captured injection fields = 0.
- Latency: a word accepted at edge N is visible on out_valid/out_cw in cycle N+1 when the queue was empty.
- Throughput: 1 word per cycle when out_ready is held high.
- Count 1 with simultaneous push and pop: count stays 1, and the new word becomes head on the next cycle.
- Count 2: in_ready = 0, so a push cannot coincide with a full queue. A pop at count 2 makes in_ready = 1 in the next cycle.
- out_valid must not drop without a pop. out_cw is held while out_valid && !out_ready.
- inj_done: exactly one cycle wide, asserted in cycle N+1 for an injection applied at edge N.
- Reset mid-operation: asynchronous clear of all state. Queued words are discarded and a pending injection is cancelled.

## Test plan
- Encode vectors, streamed with out_ready = 1:
  - in_data 0 → out_cw parity 7'b0000000
  - in_data = bit0 → parity 7'b1000011
  - in_data = bit36 → parity 7'b1101011
  - in_data = bit0|bit3 → parity 7'b1000100
  - Each appears 1 cycle after accept; word_cnt = 4 afterwards.
- Backpressure: hold out_ready = 0 and offer 3 words.
  - Required: 2 accepted, then in_ready = 0.
  - Release out_ready: words emerge in order, unchanged, and in_ready returns 1 one cycle after the first pop.
- Single injection: arm with inj_double = 0, pos0 = 40, then send data 0.
  - Required: out_cw = 44'h100_0000_0000, inj_done pulses once, inj_armed = 0.
  - The next word is uncorrupted.
- Double injection: arm with pos0 = 0, pos1 = 43, then send data bit0.
  - Required: data field 0, parity 7'b0000011.
  - Repeat with pos0 = pos1 = 5: exactly one bit flips.
- Arm coincident with accept while not armed: the accepted word is clean and the following word is corrupted. Also cover out-of-range pos0 = 50: no flip, but inj_done still pulses.
- Reset with 2 words queued and injection armed:
  - Required: out_valid = 0, in_ready = 1, inj_armed = 0, word_cnt = 0 immediately.
  - Also cover word_cnt wrap 0xFFFF → 0.

Source files
------------

// File: rtl/ecc_37_wr_enc_if.sv
// Stream, codeword and fault-injection signals of the 37-bit SECDED write-side encoder.
// The slave modport is the encoder's view, the master modport is the driver's view.
interface ecc_37_wr_enc_if #(
  parameter int DATA_WIDTH   = 37,
  parameter int PARITY_WIDTH = 7,
  parameter int CW_WIDTH     = 44
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW_WIDTH-1:0]   out_cw;
  logic                  inj_arm;
  logic                  inj_double;
  logic [5:0]            inj_pos0;
  logic [5:0]            inj_pos1;
  logic                  inj_armed;
  logic                  inj_done;
  logic [15:0]           word_cnt;

  modport slave (
    input  in_valid, in_data, out_ready,
    input  inj_arm, inj_double, inj_pos0, inj_pos1,
    output in_ready, out_valid, out_cw,
    output inj_armed, inj_done, word_cnt
  );

  modport master (
    output in_valid, in_data, out_ready,
    output inj_arm, inj_double, inj_pos0, inj_pos1,
    input  in_ready, out_valid, out_cw,
    input  inj_armed, inj_done, word_cnt
  );
endinterface

// File: rtl/ecc_37_wr_enc.sv
// Write-side SECDED encoder: 37 data bits plus 7 check bits, a 2-entry output queue,
// and a one-shot single/double bit-flip injector used to exercise the read-side checker.
module ecc_37_wr_enc #(
  parameter int DATA_WIDTH   = 37,
  parameter int PARITY_WIDTH = 7,
  parameter int CW_WIDTH     = 44
) (
  input  logic            clk,
  input  logic            rst,
  ecc_37_wr_enc_if.slave  bus
);

  // Data bit i uses the i-th integer >= 3 that is not a power of two as its code.
  // Bits 0..5 of the code select the Hamming check bits; an even popcount feeds check bit 6.
  function automatic logic [PARITY_WIDTH-1:0] f_parity(input logic [DATA_WIDTH-1:0] d);
    logic [PARITY_WIDTH-1:0] p;
    logic [5:0]              code;
    int                      idx;
    p   = '0;
    idx = 0;
    for (int v = 3; v < CW_WIDTH; v++) begin
      code = v[5:0];
      if (((code & (code - 6'd1)) != 6'd0) && (idx < DATA_WIDTH)) begin
        for (int j = 0; j < 6; j++) begin
          if (code[j]) p[j] = p[j] ^ d[idx[5:0]];
        end
        if (~^code) p[6] = p[6] ^ d[idx[5:0]];
        idx = idx + 1;
      end
    end
    return p;
  endfunction

  // Positions beyond the codeword contribute no flip.
  function automatic logic [CW_WIDTH-1:0] f_onehot(input logic [5:0] pos);
    logic [CW_WIDTH-1:0] m;
    m = '0;
    if (pos < 6'(CW_WIDTH)) m[pos] = 1'b1;
    return m;
  endfunction

  logic [CW_WIDTH-1:0] r_q [2];
  logic                r_rd;
  logic                r_wr;
  logic [1:0]          r_cnt;
  logic [15:0]         r_word_cnt;
  logic                r_armed;
  logic                r_double;
  logic [5:0]          r_pos0;
  logic [5:0]          r_pos1;
  logic                r_done;

  logic                w_accept;
  logic                w_pop;
  logic [CW_WIDTH-1:0] w_cw;
  logic [CW_WIDTH-1:0] w_mask;
  logic [CW_WIDTH-1:0] w_cw_inj;

  assign bus.in_ready  = (r_cnt != 2'd2);
  assign bus.out_valid = (r_cnt != 2'd0);
  assign bus.out_cw    = r_q[r_rd];
  assign bus.inj_armed = r_armed;
  assign bus.inj_done  = r_done;
  assign bus.word_cnt  = r_word_cnt;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_pop    = bus.out_valid && bus.out_ready;

  // Encode and inject combinationally; the result is enqueued on the accepting edge.
  always_comb begin
    w_cw     = {f_parity(bus.in_data), bus.in_data};
    w_mask   = f_onehot(r_pos0);
    if (r_double) w_mask = w_mask | f_onehot(r_pos1);
    w_cw_inj = r_armed ? (w_cw ^ w_mask) : w_cw;
  end

  // Queue storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q[0]     <= '0;
      r_q[1]     <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_cnt      <= 2'd0;
      r_word_cnt <= 16'd0;
    end else begin
      if (w_accept) begin
        r_q[r_wr]  <= w_cw_inj;
        r_wr       <= ~r_wr;
        r_word_cnt <= r_word_cnt + 16'd1;
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Injection state: a fresh arm wins over the clear caused by consuming the old one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed  <= 1'b0;
      r_double <= 1'b0;
      r_pos0   <= 6'd0;
      r_pos1   <= 6'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_accept && r_armed;
      if (bus.inj_arm) begin
        r_armed  <= 1'b1;
        r_double <= bus.inj_double;
        r_pos0   <= bus.inj_pos0;
        r_pos1   <= bus.inj_pos1;
      end else if (w_accept && r_armed) begin
        r_armed  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ecc_37_wr_enc.sv
// Directed bench for ecc_37_wr_enc: encode vectors, backpressure, injection modes,
// mid-operation reset and word counter wrap, with hand-computed codewords.
module tb_ecc_37_wr_enc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  ecc_37_wr_enc_if bus ();

  ecc_37_wr_enc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed codewords {parity, data}
  localparam logic [43:0] CW_ZERO  = {7'b0000000, 37'h0};
  localparam logic [43:0] CW_B0    = {7'b1000011, 37'h1};
  localparam logic [43:0] CW_B36   = {7'b1101011, 37'h10_0000_0000};
  localparam logic [43:0] CW_B0B3  = {7'b1000100, 37'h9};
  localparam logic [43:0] CW_B1    = {7'b1000101, 37'h2};

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus.inj_arm    = 1'b0;
    bus.inj_double = 1'b0;
    bus.inj_pos0   = 6'd0;
    bus.inj_pos1   = 6'd0;
    step();
    step();
    rst = 1'b0;
    step();

    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_cw",    64'(bus.out_cw),    64'd0);
    chk("rst_armed",     64'(bus.inj_armed), 64'd0);
    chk("rst_done",      64'(bus.inj_done),  64'd0);
    chk("rst_word_cnt",  64'(bus.word_cnt),  64'd0);

    // Streamed encode vectors
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 37'h0;
    step();
    chk("enc_zero_vld", 64'(bus.out_valid), 64'd1);
    chk("enc_zero",     64'(bus.out_cw), 64'(CW_ZERO));
    bus.in_data = 37'h1;
    step();
    chk("enc_bit0", 64'(bus.out_cw), 64'(CW_B0));
    bus.in_data = 37'h10_0000_0000;
    step();
    chk("enc_bit36", 64'(bus.out_cw), 64'(CW_B36));
    bus.in_data = 37'h9;
    step();
    chk("enc_bit0_3", 64'(bus.out_cw), 64'(CW_B0B3));
    chk("enc_word_cnt", 64'(bus.word_cnt), 64'd4);
    bus.in_valid = 1'b0;
    step();
    chk("enc_drained", 64'(bus.out_valid), 64'd0);

    // Backpressure: three words offered, two fit
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 37'h1;
    step();
    bus.in_data = 37'h10_0000_0000;
    step();
    chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
    bus.in_data = 37'h9;
    step();
    chk("bp_still_full", 64'(bus.in_ready), 64'd0);
    chk("bp_head_held",  64'(bus.out_cw), 64'(CW_B0));
    chk("bp_word_cnt",   64'(bus.word_cnt), 64'd6);
    bus.out_ready = 1'b1;
    step();
    chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
    chk("bp_second",     64'(bus.out_cw), 64'(CW_B36));
    step();
    chk("bp_third",      64'(bus.out_cw), 64'(CW_B0B3));
    chk("bp_third_vld",  64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b0;
    step();
    chk("bp_empty",      64'(bus.out_valid), 64'd0);
    chk("bp_word_cnt2",  64'(bus.word_cnt), 64'd7);

    // Single injection at codeword bit 40
    bus.inj_arm    = 1'b1;
    bus.inj_double = 1'b0;
    bus.inj_pos0   = 6'd40;
    bus.inj_pos1   = 6'd0;
    step();
    bus.inj_arm = 1'b0;
    chk("sgl_armed", 64'(bus.inj_armed), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 37'h0;
    step();
    chk("sgl_cw",       64'(bus.out_cw), 64'h100_0000_0000);
    chk("sgl_done",     64'(bus.inj_done), 64'd1);
    chk("sgl_disarmed", 64'(bus.inj_armed), 64'd0);
    bus.in_data = 37'h1;
    step();
    chk("sgl_next_clean", 64'(bus.out_cw), 64'(CW_B0));
    chk("sgl_done_once",  64'(bus.inj_done), 64'd0);
    bus.in_valid = 1'b0;
    step();

    // Double injection at bits 0 and 43
    bus.inj_arm    = 1'b1;
    bus.inj_double = 1'b1;
    bus.inj_pos0   = 6'd0;
    bus.inj_pos1   = 6'd43;
    step();
    bus.inj_arm  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 37'h1;
    step();
    chk("dbl_cw",   64'(bus.out_cw), 64'({7'b0000011, 37'h0}));
    chk("dbl_done", 64'(bus.inj_done), 64'd1);
    bus.in_valid = 1'b0;
    step();

    // Double mode with coincident positions flips one bit
    bus.inj_arm    = 1'b1;
    bus.inj_double = 1'b1;
    bus.inj_pos0   = 6'd5;
    bus.inj_pos1   = 6'd5;
    step();
    bus.inj_arm  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 37'h0;
    step();
    chk("dbl_same_pos", 64'(bus.out_cw), 64'h20);
    bus.in_valid = 1'b0;
    step();

    // Arm coincident with accept while not armed
    bus.inj_arm    = 1'b1;
    bus.inj_double = 1'b0;
    bus.inj_pos0   = 6'd2;
    bus.inj_pos1   = 6'd0;
    bus.in_valid   = 1'b1;
    bus.in_data    = 37'h0;
    step();
    bus.inj_arm = 1'b0;
    chk("coin_clean", 64'(bus.out_cw), 64'(CW_ZERO));
    chk("coin_armed", 64'(bus.inj_armed), 64'd1);
    chk("coin_no_done", 64'(bus.inj_done), 64'd0);
    step();
    chk("coin_next_flip", 64'(bus.out_cw), 64'h4);
    chk("coin_done",      64'(bus.inj_done), 64'd1);
    chk("coin_disarmed",  64'(bus.inj_armed), 64'd0);
    bus.in_valid = 1'b0;
    step();

    // Out-of-range position: no flip, done still pulses
    bus.inj_arm    = 1'b1;
    bus.inj_double = 1'b0;
    bus.inj_pos0   = 6'd50;
    step();
    bus.inj_arm  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 37'h2;
    step();
    chk("oor_cw",   64'(bus.out_cw), 64'(CW_B1));
    chk("oor_done", 64'(bus.inj_done), 64'd1);
    bus.in_valid = 1'b0;
    step();
    chk("oor_done_clr", 64'(bus.inj_done), 64'd0);

    // Reset with two words queued and an injection pending
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 37'h1;
    step();
    bus.in_data = 37'h2;
    step();
    bus.in_valid   = 1'b0;
    bus.inj_arm    = 1'b1;
    bus.inj_pos0   = 6'd7;
    step();
    bus.inj_arm = 1'b0;
    chk("pre_rst_full",  64'(bus.in_ready), 64'd0);
    chk("pre_rst_armed", 64'(bus.inj_armed), 64'd1);
    rst = 1'b1;
    #2;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("mid_rst_armed",     64'(bus.inj_armed), 64'd0);
    chk("mid_rst_word_cnt",  64'(bus.word_cnt),  64'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_empty", 64'(bus.out_valid), 64'd0);

    // Word counter wrap
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 37'h0;
    repeat (65535) step();
    chk("cnt_ffff", 64'(bus.word_cnt), 64'hFFFF);
    step();
    chk("cnt_wrap", 64'(bus.word_cnt), 64'd0);
    bus.in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
